// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronises the codec's BCLK/LRCK/DAT into the clk domain,
// deserialises MSB-first channel words and presents stereo pairs with a valid pulse.
module audio_adc_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [5:0] FULL = 6'(DATA_WIDTH);

    logic [1:0]            bclk_sync, lrck_sync, dat_sync;
    logic                  bclk_prev;
    logic                  lrck_last;
    state_t                state;
    logic [5:0]            count;
    logic                  channel;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_pending;

    logic                  bclk_rise, boundary;
    logic [DATA_WIDTH-1:0] next_word;

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign boundary  = lrck_sync[1] != lrck_last;
    assign next_word = {shift_reg, dat_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync    <= '0;
            lrck_sync    <= '0;
            dat_sync     <= '0;
            bclk_prev    <= 1'b0;
            lrck_last    <= 1'b0;
            state        <= IDLE;
            count        <= '0;
            channel      <= 1'b0;
            shift_reg    <= '0;
            left_hold    <= '0;
            left_pending <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            bclk_sync    <= {bclk_sync[0], AUD_BCLK};
            lrck_sync    <= {lrck_sync[0], AUD_ADCLRCK};
            dat_sync     <= {dat_sync[0], AUD_ADCDAT};
            bclk_prev    <= bclk_sync[1];
            sample_valid <= 1'b0;

            if (bclk_rise) begin
                lrck_last <= lrck_sync[1];
                if (boundary) begin
                    // Still in SHIFT means the word never reached full width.
                    if (state == SHIFT) begin
                        frame_err    <= 1'b1;
                        left_pending <= 1'b0;
                    end
                    state   <= SHIFT;
                    count   <= '0;
                    channel <= lrck_sync[1];
                end else if (state == SHIFT) begin
                    shift_reg <= next_word[DATA_WIDTH-2:0];
                    if (count == FULL - 6'd1) begin
                        state <= DONE;
                        count <= FULL;
                        if (!channel) begin
                            left_hold    <= next_word;
                            left_pending <= 1'b1;
                        end else if (left_pending) begin
                            left_data    <= left_hold;
                            right_data   <= next_word;
                            sample_valid <= 1'b1;
                            left_pending <= 1'b0;
                        end
                    end else begin
                        count <= count + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Randomised bench for audio_adc_rx: drives I2S slots and compares received pairs
// against a slot-level model of the pairing and framing rules.
module tb_audio_adc_rx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
    logic [DW-1:0] left_data, right_data;
    logic          sample_valid, frame_err;

    int tests = 0, fails = 0;
    int half  = 8;

    audio_adc_rx #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
        .left_data(left_data), .right_data(right_data),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot-level reference: a slot is one LRCK half-period; a new LRCK value opens
    // a word, and the first DW data bits of a slot form that channel's sample.
    logic [2*DW-1:0] exp_q[$], obs_q[$];
    logic            m_last, m_active, m_partial, m_pending, m_err;
    logic [DW-1:0]   m_hold, m_l, m_r;

    task automatic model_reset();
        m_last = 0; m_active = 0; m_partial = 0; m_pending = 0; m_err = 0;
        m_hold = '0; m_l = '0; m_r = '0;
    endtask

    task automatic model_slot(input logic ch, input int nbits, input logic [63:0] data);
        logic [DW-1:0] w;
        if (ch == m_last) return;
        m_last = ch;
        if (m_partial) begin m_err = 1; m_pending = 0; end
        m_active = 1;
        if (nbits >= DW) begin
            w = DW'(data >> (nbits - DW));
            m_partial = 0;
            if (!ch) begin
                m_hold = w; m_pending = 1;
            end else if (m_pending) begin
                exp_q.push_back({m_hold, w});
                m_l = m_hold; m_r = w; m_pending = 0;
            end
        end else begin
            m_partial = 1;
        end
    endtask

    task automatic rise(input logic ch, input logic d);
        @(negedge clk);
        bclk = 0; lrck = ch; dat = d;
        repeat (half) @(negedge clk);
        bclk = 1;
        repeat (half) @(negedge clk);
    endtask

    // One delay-slot rise (no data) followed by nbits data rises, MSB first.
    task automatic send_slot(input logic ch, input int nbits, input logic [63:0] data);
        model_slot(ch, nbits, data);
        rise(ch, 1'($urandom));
        for (int i = nbits - 1; i >= 0; i--) rise(ch, data[i]);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst = 1;
        repeat (cycles) @(negedge clk);
        rst = 0;
        model_reset();
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic compare(input string tag);
        logic [2*DW-1:0] o, e;
        // flush: the last right word is captured a few clk after its final rise
        repeat (half + 8) @(negedge clk);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            chk({tag, "_pair"}, 64'(o), 64'(e));
        end
        exp_q.delete(); obs_q.delete();
        chk({tag, "_left"}, 64'(left_data), 64'(m_l));
        chk({tag, "_right"}, 64'(right_data), 64'(m_r));
        chk({tag, "_err"}, 64'(frame_err), 64'(m_err));
    endtask

    logic prev_v = 0;
    int   dbl = 0;
    always @(negedge clk) begin
        if (!rst && sample_valid) obs_q.push_back({left_data, right_data});
        if (!rst && sample_valid && prev_v) dbl++;
        prev_v = sample_valid & ~rst;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] l, r;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_left", 64'(left_data), 0);
        chk("rst_right", 64'(right_data), 0);
        chk("rst_valid", 64'(sample_valid), 0);
        chk("rst_err", 64'(frame_err), 0);

        // Nominal: the right slot first is unpaired and dropped.
        send_slot(1, DW, 64'h5555);
        send_slot(0, DW, 64'hA5C3);
        send_slot(1, DW, 64'h1234);
        compare("nominal");

        // Wide slots: 32 data bits per channel, only the leading DW count.
        for (int f = 0; f < 4; f++) begin
            send_slot(0, 32, {16'h8001, 16'hFFFF});
            send_slot(1, 32, {16'h7FFE, 16'h0000});
        end
        compare("wide");

        // Short left word, then a full frame.
        send_slot(0, 10, 64'h2AB);
        send_slot(1, DW, 64'h00FF);
        send_slot(0, DW, 64'h1111);
        send_slot(1, DW, 64'h2222);
        compare("short");

        // Reset after 8 left bits; the rest of that slot is ignored in IDLE.
        pulse_reset(2);
        send_slot(1, DW, 64'h0F0F);
        send_slot(0, DW, 64'h3C3C);
        send_slot(1, DW, 64'hC3C3);
        compare("pre_rst");
        rise(0, 1);
        for (int i = 0; i < 8; i++) rise(0, 1'($urandom));
        pulse_reset(1);
        @(negedge clk);
        chk("midrst_left", 64'(left_data), 0);
        chk("midrst_right", 64'(right_data), 0);
        chk("midrst_err", 64'(frame_err), 0);
        for (int i = 0; i < 8; i++) rise(0, 1'($urandom));
        send_slot(1, DW, 64'h7777);
        send_slot(0, DW, 64'hCAFE);
        send_slot(1, DW, 64'hBEEF);
        compare("after_rst");

        // Reset released while LRCK is high mid right word.
        @(negedge clk);
        rst = 1; lrck = 1; bclk = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        model_reset();
        exp_q.delete(); obs_q.delete();
        send_slot(1, 9, 64'h1A5);
        for (int f = 0; f < 2; f++) begin
            l = 16'($urandom); r = 16'($urandom);
            send_slot(0, DW, 64'(l));
            send_slot(1, DW, 64'(r));
        end
        compare("midframe");

        // Back-to-back random frames at a faster bit clock.
        half = 4;
        for (int f = 0; f < 100; f++) begin
            l = 16'($urandom); r = 16'($urandom);
            send_slot(0, DW + int'($urandom_range(0, 2)), {48'(l), 16'($urandom)} >> 0);
            send_slot(1, DW, 64'(r));
        end
        compare("b2b");
        chk("no_double_valid", 64'(dbl), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
